ddr_rd_engine: RTL and testbench

- DDR read responder to the test controller's RSTART_REG/RADDR_REG/RNBURST_REG/RIDLE_REG command interface.
- On a start pulse it issues NBURST AXI4 INCR read bursts (8 beats x 64 bit) from a base address, with up to MAX_OUT bursts outstanding.
- It sinks the returned data and exports bandwidth and integrity statistics: cycle count, XOR checksum and sticky error.
- It sits between the controller FSM and the PS DDR HP port.

---
 rtl/ddr_eng_pkg.sv | 20 ++
 rtl/ddr_rd_engine.sv | 177 +++++++++++++++++
 tb/tb_ddr_rd_engine.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_eng_pkg.sv
// Shared types and AXI constants for the DDR read bandwidth engine.
package ddr_eng_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0]  AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam int unsigned BURST_BYTES    = 64;
    localparam int unsigned NBURST_W       = 24;

    // Byte offset of burst idx from the command base address.
    function automatic logic [31:0] burst_offset(input logic [NBURST_W-1:0] idx);
        return 32'(idx) * 32'(BURST_BYTES);
    endfunction

endpackage

// File: rtl/ddr_rd_engine.sv
// DDR read responder: issues NBURST AXI4 INCR bursts from a base address with
// bounded outstanding requests and accumulates cycle, checksum and error stats.
module ddr_rd_engine
    import ddr_eng_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int BLEN    = 8,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              START_REG,
    input  logic [31:0]       ADDR_REG,
    input  logic [31:0]       NBURST_REG,
    output logic              IDLE_REG,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [31:0]       CYCLES_REG,
    output logic [DATA_W-1:0] CSUM_REG,
    output logic              ERR_REG
);

    localparam int               BEAT_W    = (BLEN > 1) ? $clog2(BLEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [3:0]        OUT_MAX   = 4'(MAX_OUT);

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [NBURST_W-1:0] nburst_q;
    logic [NBURST_W-1:0] ar_cnt_q, ar_cnt_d;
    logic [NBURST_W-1:0] rl_cnt_q, rl_cnt_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [3:0]          out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q;
    logic                idle_q;
    logic [31:0]         cycles_q;
    logic [DATA_W-1:0]   csum_q;
    logic                err_q;

    logic                ar_hs_s, r_hs_s, beat_last_s, out_dec_s, beat_err_s, done_s;
    logic [ADDR_W-1:0]   start_base_s;
    logic [NBURST_W-1:0] start_nb_s;
    logic                unused_s;

    assign unused_s = ^{ADDR_REG[5:0], NBURST_REG[31:NBURST_W]};

    // Handshake decode and next values of the counters and the AR request.
    always_comb begin
        ar_hs_s     = arvalid_q & m_axi_arready;
        r_hs_s      = m_axi_rvalid & rready_q;
        beat_last_s = (beat_cnt_q == BEAT_LAST);
        // A stray rlast with nothing outstanding is flagged, never wraps the count.
        out_dec_s   = r_hs_s & m_axi_rlast & (out_cnt_q != 4'd0);
        ar_cnt_d    = ar_cnt_q + {{(NBURST_W-1){1'b0}}, ar_hs_s};
        rl_cnt_d    = rl_cnt_q + {{(NBURST_W-1){1'b0}}, r_hs_s & beat_last_s};
        if (!r_hs_s) begin
            beat_cnt_d = beat_cnt_q;
        end else if (beat_last_s) begin
            beat_cnt_d = {BEAT_W{1'b0}};
        end else begin
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
        end
        case ({ar_hs_s, out_dec_s})
            2'b10:   out_cnt_d = out_cnt_q + 4'd1;
            2'b01:   out_cnt_d = out_cnt_q - 4'd1;
            default: out_cnt_d = out_cnt_q;
        endcase
        beat_err_s   = r_hs_s & ((m_axi_rresp != RESP_OKAY) |
                                 (m_axi_rlast != beat_last_s) |
                                 (out_cnt_q == 4'd0));
        done_s       = (ar_cnt_d == nburst_q) & (rl_cnt_d == nburst_q) & (out_cnt_d == 4'd0);
        arvalid_d    = (arvalid_q & ~m_axi_arready) |
                       ((ar_cnt_d < nburst_q) & (out_cnt_d < OUT_MAX));
        araddr_d     = base_q + ADDR_W'(burst_offset(ar_cnt_d));
        start_base_s = ADDR_W'({ADDR_REG[31:6], 6'b000000});
        start_nb_s   = NBURST_REG[NBURST_W-1:0];
    end

    // Command FSM with registered AXI request, handshake bookkeeping and stats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            base_q     <= {ADDR_W{1'b0}};
            nburst_q   <= {NBURST_W{1'b0}};
            ar_cnt_q   <= {NBURST_W{1'b0}};
            rl_cnt_q   <= {NBURST_W{1'b0}};
            beat_cnt_q <= {BEAT_W{1'b0}};
            out_cnt_q  <= 4'd0;
            araddr_q   <= {ADDR_W{1'b0}};
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            idle_q     <= 1'b1;
            cycles_q   <= 32'd0;
            csum_q     <= {DATA_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START_REG) begin
                        base_q     <= start_base_s;
                        nburst_q   <= start_nb_s;
                        ar_cnt_q   <= {NBURST_W{1'b0}};
                        rl_cnt_q   <= {NBURST_W{1'b0}};
                        beat_cnt_q <= {BEAT_W{1'b0}};
                        out_cnt_q  <= 4'd0;
                        cycles_q   <= 32'd0;
                        csum_q     <= {DATA_W{1'b0}};
                        err_q      <= 1'b0;
                        if (start_nb_s != {NBURST_W{1'b0}}) begin
                            // First request goes out the cycle after START; IDLE drops with it.
                            state_q   <= ST_RUN;
                            idle_q    <= 1'b0;
                            rready_q  <= 1'b1;
                            arvalid_q <= 1'b1;
                            araddr_q  <= start_base_s;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    ar_cnt_q   <= ar_cnt_d;
                    rl_cnt_q   <= rl_cnt_d;
                    beat_cnt_q <= beat_cnt_d;
                    out_cnt_q  <= out_cnt_d;
                    araddr_q   <= araddr_d;
                    cycles_q   <= cycles_q + 32'd1;
                    err_q      <= err_q | beat_err_s;
                    if (r_hs_s) begin
                        csum_q <= csum_q ^ m_axi_rdata;
                    end
                    if (done_s) begin
                        state_q   <= ST_IDLE;
                        idle_q    <= 1'b1;
                        rready_q  <= 1'b0;
                        arvalid_q <= 1'b0;
                    end else begin
                        arvalid_q <= arvalid_d;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    idle_q    <= 1'b1;
                    rready_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign IDLE_REG      = idle_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(BLEN - 1);
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign CYCLES_REG    = cycles_q;
    assign CSUM_REG      = csum_q;
    assign ERR_REG       = err_q;

endmodule

// File: tb/tb_ddr_rd_engine.sv
// Self-checking bench for ddr_rd_engine: AXI read slave model, AR address
// scoreboard and checksum/cycle/error expectations built from driven stimulus.
module tb_ddr_rd_engine;

    localparam int BLEN    = 8;
    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] addr_i, nb_i;
    logic        idle;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] cycles;
    logic [63:0] csum;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard and slave model state.
    logic [31:0] exp_ar_q[$];
    int          sl_rdy_q[$];
    int          sl_bidx_q[$];
    int          sl_beat, issued, out_model, out_max, beats_acc, start_cyc, last_fire_cyc;
    logic [63:0] exp_csum;

    int cfg_lat, cfg_rresp_burst, cfg_rresp_beat, cfg_rlast_beat;
    bit cfg_arready_rand, cfg_data_idx;

    ddr_rd_engine #(.ADDR_W(32), .DATA_W(64), .BLEN(BLEN), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn), .START_REG(start), .ADDR_REG(addr_i), .NBURST_REG(nb_i),
        .IDLE_REG(idle), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready), .CYCLES_REG(cycles), .CSUM_REG(csum), .ERR_REG(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_defaults();
        cfg_lat = 0; cfg_rresp_burst = -1; cfg_rresp_beat = 0; cfg_rlast_beat = BLEN - 1;
        cfg_arready_rand = 1'b0; cfg_data_idx = 1'b0;
    endtask

    task automatic drive_slave();
        arready = cfg_arready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (sl_rdy_q.size() > 0 && sl_rdy_q[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = cfg_data_idx ? 64'(sl_beat) : {$urandom, $urandom};
            rresp  = (sl_bidx_q[0] == cfg_rresp_burst && sl_beat == cfg_rresp_beat) ? 2'b10 : 2'b00;
            rlast  = (sl_beat == cfg_rlast_beat);
        end else begin
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 64'd0;
        end
    endtask

    task automatic run_cmd(input logic [31:0] addr, input logic [31:0] nb, input int abort_after,
                           output logic idle_after_start, output int end_cyc);
        logic [31:0] base, held_addr, exp_a;
        bit          ar_fire, r_fire, held_prev, done;
        int          n;
        base = {addr[31:6], 6'b000000};
        for (int i = 0; i < int'(nb[23:0]); i++) exp_ar_q.push_back(base + 32'(i) * 32'd64);
        exp_csum = 64'd0; beats_acc = 0; out_model = 0; out_max = 0; issued = 0; sl_beat = 0;
        last_fire_cyc = 0; held_prev = 1'b0; held_addr = 32'd0; done = 1'b0; end_cyc = 0;
        start = 1'b1; addr_i = addr; nb_i = nb;
        @(posedge clk); #1;
        start = 1'b0; start_cyc = cyc;
        idle_after_start = idle;
        drive_slave();
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            if (held_prev) begin
                checks++;
                if (arvalid !== 1'b1 || araddr !== held_addr) begin
                    failures++;
                    $display("FAIL ar_hold got valid=%b addr=%h exp valid=1 addr=%h", arvalid, araddr, held_addr);
                end
            end
            ar_fire   = arvalid & arready;
            r_fire    = rvalid & rready;
            held_prev = arvalid & ~arready;
            held_addr = araddr;
            if (ar_fire) begin
                checks++;
                if (exp_ar_q.size() == 0) begin
                    failures++;
                    $display("FAIL ar_addr got=%h exp=none (extra request)", araddr);
                end else begin
                    exp_a = exp_ar_q.pop_front();
                    if (araddr !== exp_a) begin
                        failures++;
                        $display("FAIL ar_addr got=%h exp=%h", araddr, exp_a);
                    end
                end
                sl_rdy_q.push_back(cyc + 1 + cfg_lat);
                sl_bidx_q.push_back(issued);
                issued++; out_model++;
            end
            if (r_fire) begin
                exp_csum ^= rdata; beats_acc++; last_fire_cyc = cyc + 1;
                if (rlast && out_model > 0) out_model--;
            end
            if (out_model > out_max) out_max = out_model;
            @(posedge clk); #1;
            if (r_fire) begin
                sl_beat++;
                if (sl_beat == BLEN) begin
                    sl_beat = 0;
                    void'(sl_rdy_q.pop_front());
                    void'(sl_bidx_q.pop_front());
                end
            end
            drive_slave();
            n++;
            if (idle === 1'b1) begin
                done = 1'b1; end_cyc = cyc;
            end else if (abort_after != 0 && n >= abort_after) begin
                break;
            end
        end
        if (abort_after == 0) begin
            checks++;
            if (!done) begin
                failures++;
                $display("FAIL run_timeout got idle=%b exp idle=1 within budget", idle);
            end
            checks++;
            if (exp_ar_q.size() != 0) begin
                failures++;
                $display("FAIL ar_count got missing=%0d exp missing=0", exp_ar_q.size());
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
        checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rst_rready got=%b exp=0", rready); end
        checks++; if (araddr !== 32'd0) begin failures++; $display("FAIL rst_araddr got=%h exp=0", araddr); end
        checks++; if (cycles !== 32'd0 || csum !== 64'd0 || err !== 1'b0) begin
            failures++; $display("FAIL rst_stats got cyc=%0d csum=%h err=%b exp 0/0/0", cycles, csum, err);
        end
    endtask

    task automatic test_single();
        logic ia; int ec;
        set_defaults(); cfg_data_idx = 1'b1;
        run_cmd(32'h1000_0000, 32'd1, 0, ia, ec);
        checks++; if (ia !== 1'b0) begin failures++; $display("FAIL idle_after_start got=%b exp=0", ia); end
        checks++; if (arlen !== 8'd7 || arsize !== 3'd3 || arburst !== 2'd1) begin
            failures++; $display("FAIL ar_const got len=%0d size=%0d burst=%0d exp 7/3/1", arlen, arsize, arburst);
        end
        checks++; if (csum !== exp_csum || csum !== 64'd0) begin failures++; $display("FAIL single_csum got=%h exp=%h", csum, exp_csum); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
        checks++; if (beats_acc != BLEN) begin failures++; $display("FAIL single_beats got=%0d exp=%0d", beats_acc, BLEN); end
        checks++; if (ec != last_fire_cyc) begin failures++; $display("FAIL single_idle_edge got=%0d exp=%0d", ec, last_fire_cyc); end
        checks++; if (cycles !== 32'(last_fire_cyc - start_cyc)) begin
            failures++; $display("FAIL single_cycles got=%0d exp=%0d", cycles, last_fire_cyc - start_cyc);
        end
    endtask

    task automatic test_outstanding();
        logic ia; int ec;
        set_defaults(); cfg_lat = 20;
        run_cmd(32'h2000_0000, 32'd16, 0, ia, ec);
        checks++; if (out_max != MAX_OUT) begin failures++; $display("FAIL out_max got=%0d exp=%0d", out_max, MAX_OUT); end
        checks++; if (beats_acc != 128) begin failures++; $display("FAIL out_beats got=%0d exp=128", beats_acc); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL out_err got=%b exp=0", err); end
        checks++; if (csum !== exp_csum) begin failures++; $display("FAIL out_csum got=%h exp=%h", csum, exp_csum); end
        checks++; if (cycles !== 32'(last_fire_cyc - start_cyc)) begin
            failures++; $display("FAIL out_cycles got=%0d exp=%0d", cycles, last_fire_cyc - start_cyc);
        end
    endtask

    task automatic test_wrap();
        logic ia; int ec;
        set_defaults();
        run_cmd(32'hFFFF_FFC0, 32'd2, 0, ia, ec);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", err); end
        checks++; if (csum !== exp_csum) begin failures++; $display("FAIL wrap_csum got=%h exp=%h", csum, exp_csum); end
    endtask

    task automatic test_zero_nburst();
        bit saw_ar, saw_busy;
        set_defaults();
        start = 1'b1; addr_i = 32'h4000_0000; nb_i = 32'h0100_0000;
        @(posedge clk); #1;
        start = 1'b0; saw_ar = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (arvalid !== 1'b0) saw_ar = 1'b1;
            if (idle !== 1'b1 || rready !== 1'b0) saw_busy = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_ar) begin failures++; $display("FAIL zero_arvalid got=1 exp=0"); end
        checks++; if (saw_busy) begin failures++; $display("FAIL zero_idle got busy exp idle=1 rready=0"); end
        checks++; if (cycles !== 32'd0 || csum !== 64'd0 || err !== 1'b0) begin
            failures++; $display("FAIL zero_stats got cyc=%0d csum=%h err=%b exp 0/0/0", cycles, csum, err);
        end
    endtask

    task automatic test_rresp_err();
        logic ia; int ec;
        set_defaults(); cfg_rresp_burst = 1; cfg_rresp_beat = 3;
        run_cmd(32'h5000_0040, 32'd2, 0, ia, ec);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rresp_err got=%b exp=1", err); end
        checks++; if (csum !== exp_csum) begin failures++; $display("FAIL rresp_csum got=%h exp=%h", csum, exp_csum); end
        set_defaults();
        run_cmd(32'h5000_1000, 32'd1, 0, ia, ec);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
    endtask

    task automatic test_early_rlast();
        logic ia; int ec;
        set_defaults(); cfg_rlast_beat = 5;
        run_cmd(32'h6000_0000, 32'd1, 0, ia, ec);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL early_rlast_err got=%b exp=1", err); end
        checks++; if (ec != last_fire_cyc) begin failures++; $display("FAIL early_rlast_end got=%0d exp=%0d", ec, last_fire_cyc); end
    endtask

    task automatic test_reset_mid_run();
        logic ia; int ec;
        set_defaults();
        run_cmd(32'h3000_0000, 32'd8, 9, ia, ec);
        #2 rstn = 1'b0;
        #1;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || idle !== 1'b1) begin
            failures++; $display("FAIL midrst_ctrl got arvalid=%b rready=%b idle=%b exp 0/0/1", arvalid, rready, idle);
        end
        checks++; if (cycles !== 32'd0 || csum !== 64'd0 || err !== 1'b0 || araddr !== 32'd0) begin
            failures++; $display("FAIL midrst_stats got cyc=%0d csum=%h err=%b addr=%h exp all 0", cycles, csum, err, araddr);
        end
        exp_ar_q.delete(); sl_rdy_q.delete(); sl_bidx_q.delete(); sl_beat = 0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 64'd0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        run_cmd(32'h3000_0100, 32'd2, 0, ia, ec);
        checks++; if (err !== 1'b0 || csum !== exp_csum) begin
            failures++; $display("FAIL midrst_rerun got err=%b csum=%h exp err=0 csum=%h", err, csum, exp_csum);
        end
    endtask

    task automatic test_ar_stall();
        logic ia; int ec;
        set_defaults(); cfg_arready_rand = 1'b1; cfg_lat = 1;
        run_cmd(32'h7000_0200, 32'd4, 0, ia, ec);
        checks++; if (err !== 1'b0 || csum !== exp_csum) begin
            failures++; $display("FAIL stall_stats got err=%b csum=%h exp err=0 csum=%h", err, csum, exp_csum);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; addr_i = 32'd0; nb_i = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 64'd0; rresp = 2'b00; rlast = 1'b0;
        set_defaults();
        repeat (3) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_outstanding();
        test_wrap();
        test_zero_nburst();
        test_rresp_err();
        test_early_rlast();
        test_reset_mid_run();
        test_ar_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
